// File: rtl/fbuf_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin sharing of one write port
// between the CPU store port and the graphics engine, plus a fill engine
// that takes the port exclusively and writes every word with one colour.
module fbuf_write_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 4,
   parameter int FILL_LEN = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_valid,
   output logic              cpu_ready,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   input  logic              gfx_valid,
   output logic              gfx_ready,
   input  logic [ADDR_W-1:0] gfx_addr,
   input  logic [DATA_W-1:0] gfx_data,
   input  logic              fill_start,
   input  logic [DATA_W-1:0] fill_color,
   output logic              fill_busy,
   output logic              fill_done,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_waddr,
   output logic [DATA_W-1:0] fb_din
);

   // Counter holds 0..FILL_LEN inclusive so the terminal value is representable.
   localparam int CNT_W = $clog2(FILL_LEN) + 1;

   localparam logic [0:0] ST_ARB  = 1'b0;
   localparam logic [0:0] ST_FILL = 1'b1;

   localparam logic RR_CPU = 1'b0;
   localparam logic RR_GFX = 1'b1;

   logic [0:0]        state_q,     state_d;
   logic              rr_last_q,   rr_last_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [DATA_W-1:0] color_q,     color_d;
   logic              fb_we_q,     fb_we_d;
   logic [ADDR_W-1:0] fb_waddr_q,  fb_waddr_d;
   logic [DATA_W-1:0] fb_din_q,    fb_din_d;
   logic              fill_done_q, fill_done_d;

   logic              cpu_grant;
   logic              gfx_grant;

   // Grant decision: a fill request or reset blocks both clients; when both
   // ask, the client that did not win the last transfer goes first.
   always_comb begin
      cpu_grant = 1'b0;
      gfx_grant = 1'b0;
      if (!rst && (state_q == ST_ARB) && !fill_start) begin
         if (cpu_valid && gfx_valid) begin
            if (rr_last_q == RR_GFX) begin
               cpu_grant = 1'b1;
            end else begin
               gfx_grant = 1'b1;
            end
         end else begin
            cpu_grant = cpu_valid;
            gfx_grant = gfx_valid;
         end
      end
   end

   // Next-state logic: the fill_start cycle already issues fill word 0, so
   // the port shows exactly FILL_LEN fill writes while fill_busy is high.
   always_comb begin
      state_d     = state_q;
      rr_last_d   = rr_last_q;
      cnt_d       = cnt_q;
      color_d     = color_q;
      fb_we_d     = 1'b0;
      fb_waddr_d  = fb_waddr_q;
      fb_din_d    = fb_din_q;
      fill_done_d = 1'b0;

      if (state_q == ST_ARB) begin
         if (fill_start) begin
            state_d    = ST_FILL;
            color_d    = fill_color;
            cnt_d      = CNT_W'(1);
            fb_we_d    = 1'b1;
            fb_waddr_d = '0;
            fb_din_d   = fill_color;
         end else if (cpu_grant) begin
            fb_we_d    = 1'b1;
            fb_waddr_d = cpu_addr;
            fb_din_d   = cpu_data;
            rr_last_d  = RR_CPU;
         end else if (gfx_grant) begin
            fb_we_d    = 1'b1;
            fb_waddr_d = gfx_addr;
            fb_din_d   = gfx_data;
            rr_last_d  = RR_GFX;
         end
      end else begin
         // fill_start is deliberately ignored here: no restart, colour kept.
         if (cnt_q < CNT_W'(FILL_LEN)) begin
            fb_we_d    = 1'b1;
            fb_waddr_d = ADDR_W'(cnt_q);
            fb_din_d   = color_q;
            cnt_d      = cnt_q + CNT_W'(1);
         end else begin
            state_d     = ST_ARB;
            cnt_d       = '0;
            fill_done_d = 1'b1;
         end
      end
   end

   // State and output registers; reset also aborts any fill in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ARB;
         rr_last_q   <= RR_GFX;
         cnt_q       <= '0;
         color_q     <= '0;
         fb_we_q     <= 1'b0;
         fb_waddr_q  <= '0;
         fb_din_q    <= '0;
         fill_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_last_q   <= rr_last_d;
         cnt_q       <= cnt_d;
         color_q     <= color_d;
         fb_we_q     <= fb_we_d;
         fb_waddr_q  <= fb_waddr_d;
         fb_din_q    <= fb_din_d;
         fill_done_q <= fill_done_d;
      end
   end

   assign cpu_ready = cpu_grant;
   assign gfx_ready = gfx_grant;
   assign fill_busy = (state_q == ST_FILL);
   assign fill_done = fill_done_q;
   assign fb_we     = fb_we_q;
   assign fb_waddr  = fb_waddr_q;
   assign fb_din    = fb_din_q;

endmodule
